dsp_two_mult_driver: RTL

- Streaming front/back end for the two-multiplier/one-adder DSP block; the initiator side of its operand/result interface.
- Accepts operand bundles on a valid/ready stream and launches them into the DSP.
- Drives the DSP mode lines one cycle after the operands, matching the DSP's unregistered mode sampling.
- Captures the 72-bit DSP result, decodes it by mode, and buffers it in a result FIFO; credit-based issue guarantees no result is ever lost under output backpressure.

---
 rtl/dsp_driver_pkg.sv | 45 ++++
 rtl/dsp_result_fifo.sv | 69 ++++++
 rtl/dsp_two_mult_driver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dsp_driver_pkg.sv
// ============================================================================
// Module      : dsp_driver_pkg
// Description : Shared types, widths and result decode for the two-multiplier
//               DSP driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_driver_pkg;

    localparam int OPW = 18;
    localparam int PW  = 72;

    typedef enum logic [1:0] {
        MODE_SUM    = 2'b00,
        MODE_DUAL   = 2'b01,
        MODE_SINGLE = 2'b10
    } mode_e;

    // The mode field is kept raw so that 2'b11 (also SINGLE) is reported back as issued.
    typedef struct packed {
        logic [1:0]  mode;
        logic [36:0] r0;
        logic [35:0] r1;
    } result_t;

    function automatic result_t decode_result(input logic [1:0] mode, input logic [PW-1:0] p);
        result_t res;
        res.mode = mode;
        res.r0   = '0;
        res.r1   = '0;
        if (mode == MODE_SUM) begin
            res.r0 = p[36:0];
        end else if (mode == MODE_DUAL) begin
            res.r0 = {1'b0, p[71:36]};
            res.r1 = p[35:0];
        end else begin
            res.r0 = {1'b0, p[35:0]};
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_result_fifo.sv
// ============================================================================
// Module      : dsp_result_fifo
// Description : Synchronous FIFO with a registered head entry and valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_result_fifo
    import dsp_driver_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = result_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [AW:0]     count_next;
    logic            do_pop;

    assign do_pop     = pop & valid;
    assign rd_next    = rd_ptr + 1'b1;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            count <= count_next;
            valid <= (count_next != '0);
            // Head reload: next stored entry, or the pushed entry when storage runs dry.
            if (do_pop) begin
                if (count > (AW+1)'(1)) begin
                    head <= mem[rd_next];
                end else if (push) begin
                    head <= push_data;
                end
            end else if ((count == '0) && push) begin
                head <= push_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dsp_two_mult_driver.sv
// ============================================================================
// Module      : dsp_two_mult_driver
// Description : Stream initiator for the two-multiplier DSP with credit-based
//               result buffering. Optional macro DSP_DRIVER_STATS_EN adds
//               accept/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_two_mult_driver
    import dsp_driver_pkg::*;
#(
    parameter int OPW        = 18,
    parameter int PW         = 72,
    parameter int FIFO_DEPTH = 4,
    parameter int DSP_LAT    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_a0,
    input  logic [OPW-1:0] in_b0,
    input  logic [OPW-1:0] in_a1,
    input  logic [OPW-1:0] in_b1,
    input  logic [1:0]     in_mode,
    output logic [OPW-1:0] dsp_a0,
    output logic [OPW-1:0] dsp_b0,
    output logic [OPW-1:0] dsp_a1,
    output logic [OPW-1:0] dsp_b1,
    output logic           dsp_mode_0,
    output logic           dsp_mode_1,
    input  logic [PW-1:0]  dsp_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     out_mode,
    output logic [36:0]    out_r0,
    output logic [35:0]    out_r1
`ifdef DSP_DRIVER_STATS_EN
    ,
    output logic [31:0]    stat_ops,
    output logic [31:0]    stat_stall
`endif
);

    logic                        launch;
    logic [DSP_LAT-1:0]          tag_valid;
    logic [1:0]                  tag_mode [DSP_LAT];
    logic [31:0]                 inflight;
    logic [31:0]                 credit_used;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    result_t                     capture_data;
    result_t                     head;

    assign launch = in_valid & in_ready;

    assign dsp_a0 = launch ? in_a0 : '0;
    assign dsp_b0 = launch ? in_b0 : '0;
    assign dsp_a1 = launch ? in_a1 : '0;
    assign dsp_b1 = launch ? in_b1 : '0;

    // The DSP samples mode unregistered one cycle after its operands.
    assign dsp_mode_0 = tag_valid[0] & tag_mode[0][0];
    assign dsp_mode_1 = tag_valid[0] & tag_mode[0][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= '0;
            for (int i = 0; i < DSP_LAT; i++) begin
                tag_mode[i] <= 2'b00;
            end
        end else begin
            tag_valid[0] <= launch;
            tag_mode[0]  <= launch ? in_mode : 2'b00;
            for (int i = 1; i < DSP_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_mode[i]  <= tag_mode[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DSP_LAT; i++) begin
            inflight = inflight + 32'(tag_valid[i]);
        end
    end

    // Registered occupancy means a pop returns its credit only on the following cycle.
    assign credit_used = 32'(fifo_count) + inflight;
    assign in_ready    = !reset && (credit_used < 32'(FIFO_DEPTH));

    assign capture_data = decode_result(tag_mode[DSP_LAT-1], dsp_p);

    dsp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (result_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_valid[DSP_LAT-1]),
        .push_data (capture_data),
        .pop       (out_ready),
        .head      (head),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_mode = head.mode;
    assign out_r0   = head.r0;
    assign out_r1   = head.r1;

`ifdef DSP_DRIVER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (launch && (stat_ops != '1)) begin
                stat_ops <= stat_ops + 1'b1;
            end
            if (in_valid && !in_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
